// File: rtl/io_uart_responder_if.sv
// rtl/io_uart_responder_if.sv - CPU IO bus bundle between the bus master and the UART responder
interface io_uart_responder_if;
    logic        strobe;
    logic        isIO;
    logic [31:0] port;
    logic [3:0]  size;
    logic        rw;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        rvalid;

    modport master (output strobe, isIO, port, size, rw, wdata, input rdata, rvalid);
    modport slave  (input strobe, isIO, port, size, rw, wdata, output rdata, rvalid);
endinterface

// File: rtl/io_uart_responder.sv
// rtl/io_uart_responder.sv - IO-mapped 8N1 serial transmitter with TX FIFO and status/divisor registers
module io_uart_responder #(
    parameter logic [31:0] BASE        = 32'h0000_1000,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic                 clk,
    input  logic                 reset,
    io_uart_responder_if.slave   bus,
    output logic                 tx,
    output logic                 irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic [15:0]     div;
    logic [15:0]     tick;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic            hit, wr_hit, rd_hit, push_req, push_ok, pop;
    logic            full, empty, busy, bit_end;
    logic [3:0]      offset;
    logic [63:0]     rd_val;
    logic            unused;

    assign unused   = ^bus.wdata[63:16];
    assign offset   = bus.port[3:0];
    assign hit      = bus.strobe & bus.isIO & (bus.size != 4'd0) & (bus.port[31:4] == BASE[31:4]);
    assign wr_hit   = hit & bus.rw;
    assign rd_hit   = hit & ~bus.rw;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != S_IDLE);
    assign bit_end  = (tick == 16'd0);
    assign push_req = wr_hit & (offset == 4'h0);
    // A full FIFO still accepts a byte when the serialiser frees a slot in the same cycle
    assign push_ok  = push_req & (~full | pop);
    assign irq      = empty & ~busy;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = S_START;
            end
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP: if (bit_end) begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        if (state == S_START)     tx = 1'b0;
        else if (state == S_DATA) tx = shreg[0];
    end

    always_comb begin
        rd_val = 64'd0;
        case (offset)
            4'h4: rd_val = {53'd0, 7'(count), ovf, busy, empty, full};
            4'h8: rd_val = {48'd0, div};
            default: rd_val = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            div        <= DEFAULT_DIV;
            tick       <= 16'd0;
            bit_idx    <= 3'd0;
            shreg      <= 8'hFF;
            bus.rdata  <= 64'd0;
            bus.rvalid <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);

            if (push_req && !push_ok)                          ovf <= 1'b1;
            else if (wr_hit && offset == 4'h4 && bus.wdata[3]) ovf <= 1'b0;

            if (wr_hit && offset == 4'h8) div <= bus.wdata[15:0];

            // Divisor is sampled only at bit boundaries so a DIV write never stretches the current bit
            if (pop || (busy && bit_end)) tick <= div;
            else if (busy)                tick <= tick - 16'd1;

            if (state == S_START)                  bit_idx <= 3'd0;
            else if (state == S_DATA && bit_end)   bit_idx <= bit_idx + 3'd1;

            if (pop)                               shreg <= mem[rd_ptr];
            else if (state == S_DATA && bit_end)   shreg <= {1'b1, shreg[7:1]};

            bus.rvalid <= rd_hit;
            bus.rdata  <= rd_hit ? rd_val : 64'd0;
        end
    end
endmodule

// File: tb/tb_io_uart_responder.sv
// tb/tb_io_uart_responder.sv - self-checking bench for io_uart_responder
module tb_io_uart_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DDIV  = 16'd867;

    logic clk = 1'b0;
    logic reset;
    logic tx, irq;
    int   checks = 0;
    int   failures = 0;

    io_uart_responder_if bus ();

    io_uart_responder #(.BASE(BASE), .DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] st(input int cnt, input bit ovf, input bit busy);
        logic [63:0] r;
        r = 64'd0;
        r[0] = (cnt == DEPTH);
        r[1] = (cnt == 0);
        r[2] = busy;
        r[3] = ovf;
        r[10:4] = 7'(cnt);
        return r;
    endfunction

    task automatic access(input bit io, input logic [31:0] p, input logic [3:0] sz,
                          input bit w, input logic [63:0] d);
        bus.strobe = 1'b1;
        bus.isIO   = io;
        bus.port   = p;
        bus.size   = sz;
        bus.rw     = w;
        bus.wdata  = d;
        step();
        bus.strobe = 1'b0;
        bus.isIO   = 1'b0;
        bus.rw     = 1'b0;
        bus.wdata  = 64'd0;
    endtask

    task automatic wr(input logic [31:0] p, input logic [63:0] d);
        access(1'b1, p, 4'd4, 1'b1, d);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        logic [63:0] d;
        logic [3:0]  sz;
        d  = {$urandom, $urandom};
        d[7:0] = b;
        sz = 4'(1 << $urandom_range(0, 3));
        access(1'b1, BASE, sz, 1'b1, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] p, input logic [63:0] exp);
        access(1'b1, p, 4'd4, 1'b0, 64'd0);
        chk({tag, "_rvalid"}, 64'(bus.rvalid), 64'd1);
        chk(tag, bus.rdata, exp);
    endtask

    // 8N1 line model: start 0, data LSB first, stop 1, each bit d+1 clocks, frames back-to-back
    task automatic check_stream(input bit [7:0] q[$], input int d);
        logic e;
        for (int f = 0; f < q.size(); f++) begin
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      e = 1'b0;
                else if (b == 9) e = 1'b1;
                else             e = q[f][b-1];
                for (int r = 0; r <= d; r++) begin
                    step();
                    chk($sformatf("tx_f%0d_b%0d_c%0d", f, b, r), 64'(tx), 64'(e));
                end
            end
        end
    endtask

    initial begin
        bit [7:0] q1[$];
        bit [7:0] q3[$];
        bit [7:0] q4[$];
        bit [7:0] bytes[10];

        reset = 1'b1;
        bus.strobe = 1'b0; bus.isIO = 1'b0; bus.port = 32'd0;
        bus.size = 4'd0; bus.rw = 1'b0; bus.wdata = 64'd0;
        step();
        step();
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_irq", 64'(irq), 64'd1);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        reset = 1'b0;

        rd_chk("status_reset", BASE + 4, st(0, 0, 0));
        step();
        chk("rvalid_one_cycle", 64'(bus.rvalid), 64'd0);
        chk("rdata_idle_zero", bus.rdata, 64'd0);
        rd_chk("div_reset", BASE + 8, 64'(DDIV));

        // Non-hit accesses
        access(1'b0, BASE + 8, 4'd4, 1'b1, 64'd5);
        chk("nohit_io_rvalid", 64'(bus.rvalid), 64'd0);
        access(1'b1, BASE + 32'h10, 4'd4, 1'b0, 64'd0);
        chk("nohit_port_rvalid", 64'(bus.rvalid), 64'd0);
        access(1'b1, BASE + 32'h14, 4'd4, 1'b1, 64'd0);
        access(1'b1, BASE, 4'd0, 1'b1, 64'h55);
        access(1'b0, BASE + 4, 4'd4, 1'b0, 64'd0);
        chk("nohit_io_rd_rvalid", 64'(bus.rvalid), 64'd0);
        access(1'b1, BASE + 4, 4'd0, 1'b0, 64'd0);
        chk("nohit_size_rvalid", 64'(bus.rvalid), 64'd0);
        rd_chk("status_after_nohit", BASE + 4, st(0, 0, 0));
        rd_chk("div_after_nohit", BASE + 8, 64'(DDIV));
        rd_chk("rd_off_c", BASE + 12, 64'd0);
        rd_chk("rd_txdata", BASE, 64'd0);
        chk("tx_idle", 64'(tx), 64'd1);

        // Single frame, DIV=3
        wr(BASE + 8, 64'd3);
        rd_chk("div_3", BASE + 8, 64'd3);
        wr_byte(8'hA5);
        chk("frame_pop_cycle_tx", 64'(tx), 64'd1);
        q1.push_back(8'hA5);
        check_stream(q1, 3);
        chk("frame_last_irq", 64'(irq), 64'd0);
        step();
        chk("frame_done_irq", 64'(irq), 64'd1);
        chk("frame_done_tx", 64'(tx), 64'd1);

        // Overflow with DIV=100
        wr(BASE + 8, 64'd100);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) q3.push_back(bytes[i]);
        wr_byte(bytes[0]);
        fork
            begin
                for (int i = 1; i < 10; i++) wr_byte(bytes[i]);
                rd_chk("status_ovf", BASE + 4, st(DEPTH, 1, 1));
                wr(BASE + 4, 64'h8);
                rd_chk("status_ovf_clr", BASE + 4, st(DEPTH, 0, 1));
            end
            check_stream(q3, 100);
        join
        step();
        chk("ovf_done_irq", 64'(irq), 64'd1);
        rd_chk("ovf_done_status", BASE + 4, st(0, 0, 0));

        // Push into full FIFO in the same cycle STOP ends and pops
        wr(BASE + 8, 64'd3);
        for (int i = 0; i < 10; i++) begin
            bytes[i] = 8'($urandom);
            q4.push_back(bytes[i]);
        end
        wr_byte(bytes[0]);
        fork
            begin
                for (int i = 1; i < 9; i++) wr_byte(bytes[i]);
                repeat (32) step();
                wr_byte(bytes[9]);
                rd_chk("status_full_pop", BASE + 4, st(DEPTH, 0, 1));
            end
            check_stream(q4, 3);
        join
        step();
        chk("full_pop_done_irq", 64'(irq), 64'd1);

        // Reset during data bit 3
        wr(BASE + 8, 64'd3);
        wr_byte(8'($urandom));
        wr_byte(8'($urandom));
        repeat (17) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_irq", 64'(irq), 64'd1);
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        rd_chk("midrst_status", BASE + 4, st(0, 0, 0));
        rd_chk("midrst_div", BASE + 8, 64'(DDIV));
        repeat (5) step();
        chk("midrst_tx_stays", 64'(tx), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
